// File: rtl/host_cmd_pkg.sv
// host_cmd_tx shared definitions.
// Frame codes, command encodings, serializer states, byte counts.
package host_cmd_pkg;

  localparam logic [7:0] CODE_WR     = 8'hAA;
  localparam logic [7:0] CODE_RD     = 8'hBB;
  localparam logic [7:0] CODE_ALU_OP = 8'hCC;
  localparam logic [7:0] CODE_ALU    = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WR     = 2'd0,
    CMD_RD     = 2'd1,
    CMD_ALU_OP = 2'd2,
    CMD_ALU    = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } ser_state_e;

  localparam logic [2:0] NB_WR     = 3'd3;
  localparam logic [2:0] NB_RD     = 3'd2;
  localparam logic [2:0] NB_ALU_OP = 3'd4;
  localparam logic [2:0] NB_ALU    = 3'd2;

  function automatic logic [2:0] cmd_nbytes(cmd_type_e t);
    logic [2:0] n;
    case (t)
      CMD_WR:     n = NB_WR;
      CMD_RD:     n = NB_RD;
      CMD_ALU_OP: n = NB_ALU_OP;
      default:    n = NB_ALU;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] cmd_code(cmd_type_e t);
    logic [7:0] c;
    case (t)
      CMD_WR:     c = CODE_WR;
      CMD_RD:     c = CODE_RD;
      CMD_ALU_OP: c = CODE_ALU_OP;
      default:    c = CODE_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/host_cmd_tx_uart_byte_ser.sv
// One UART character: start, data LSB first, parity, stop.
// A load in the last stop cycle chains the next byte with no gap.
module uart_byte_ser
  import host_cmd_pkg::*;
#(
  parameter int BIT_CYCLES = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  idle,
  output logic                  done,
  output logic                  tx
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]    CNT_MAX = 8'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

  ser_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  pbit_q, pbit_d;
  logic                  pen_q, pen_d;
  logic                  tx_q, tx_d;
  logic                  tick;
  logic                  take;

  assign tick = (cnt_q == CNT_MAX);
  assign idle = (state_q == S_IDLE);
  assign take = load &&
    (idle || (state_q == S_STOP && tick));
  assign tx   = tx_q;

  // next state, next line level and byte-done pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = (idle || tick) ? 8'd0 : cnt_q + 8'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pbit_d  = pbit_q;
    pen_d   = pen_q;
    tx_d    = tx_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: tx_d = 1'b1;
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = sh_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
            tx_d    = pen_q ? pbit_q : 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
            sh_d  = sh_q >> 1;
            tx_d  = sh_d[0];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          done    = 1'b1;
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (take) begin
      state_d = S_START;
      tx_d    = 1'b0;
      sh_d    = byte_in;
      pbit_d  = (^byte_in) ^ par_typ;
      pen_d   = par_en;
      idx_d   = '0;
    end
  end

  // serializer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      pbit_q  <= 1'b0;
      pen_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      pbit_q  <= pbit_d;
      pen_q   <= pen_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/host_cmd_tx.sv
// Host command transmitter: captures a command and sends
// its byte sequence as back-to-back UART characters.
module host_cmd_tx
  import host_cmd_pkg::*;
#(
  parameter int BIT_CYCLES    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_TYPE,
  input  logic [ADDRESS_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]    CMD_DATA,
  input  logic [DATA_WIDTH-1:0]    CMD_OPB,
  input  logic [ALU_FUN_WIDTH-1:0] CMD_FUN,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  output logic                     TX_OUT,
  output logic                     BUSY,
  output logic                     FRAME_DONE
);

  cmd_type_e                typ_q, typ_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [DATA_WIDTH-1:0]    opb_q, opb_d;
  logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;
  logic                     pen_q, pen_d;
  logic                     ptyp_q, ptyp_d;
  logic [1:0]               bidx_q, bidx_d;

  logic                  ser_idle;
  logic                  ser_done;
  logic                  ser_load;
  logic                  ser_pen;
  logic                  ser_ptyp;
  logic [DATA_WIDTH-1:0] byte_sel;
  logic                  accept;
  logic                  last;
  logic [1:0]            nidx;

  assign accept     = CMD_VALID && ser_idle;
  assign CMD_READY  = ser_idle;
  assign BUSY       = !ser_idle;
  assign last       = (bidx_q ==
    2'(cmd_nbytes(typ_q) - 3'd1));
  assign nidx       = bidx_q + 2'd1;
  assign FRAME_DONE = ser_done && last;
  assign ser_load   = accept || (ser_done && !last);
  assign ser_pen    = accept ? PAR_EN : pen_q;
  assign ser_ptyp   = accept ? PAR_TYP : ptyp_q;

  // command capture and byte index
  always_comb begin
    typ_d  = typ_q;
    addr_d = addr_q;
    data_d = data_q;
    opb_d  = opb_q;
    fun_d  = fun_q;
    pen_d  = pen_q;
    ptyp_d = ptyp_q;
    bidx_d = bidx_q;
    if (accept) begin
      typ_d  = cmd_type_e'(CMD_TYPE);
      addr_d = CMD_ADDR;
      data_d = CMD_DATA;
      opb_d  = CMD_OPB;
      fun_d  = CMD_FUN;
      pen_d  = PAR_EN;
      ptyp_d = PAR_TYP;
      bidx_d = 2'd0;
    end else if (ser_done) begin
      bidx_d = last ? 2'd0 : nidx;
    end
  end

  // byte to load: frame code on accept, else next field
  always_comb begin
    byte_sel = '0;
    if (accept) begin
      byte_sel = DATA_WIDTH'(
        cmd_code(cmd_type_e'(CMD_TYPE)));
    end else begin
      case (typ_q)
        CMD_WR:
          byte_sel = (nidx == 2'd1) ?
            DATA_WIDTH'(addr_q) : data_q;
        CMD_RD:
          byte_sel = DATA_WIDTH'(addr_q);
        CMD_ALU_OP: begin
          case (nidx)
            2'd1:    byte_sel = data_q;
            2'd2:    byte_sel = opb_q;
            default: byte_sel = DATA_WIDTH'(fun_q);
          endcase
        end
        default:
          byte_sel = DATA_WIDTH'(fun_q);
      endcase
    end
  end

  // captured command registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      typ_q  <= CMD_WR;
      addr_q <= '0;
      data_q <= '0;
      opb_q  <= '0;
      fun_q  <= '0;
      pen_q  <= 1'b0;
      ptyp_q <= 1'b0;
      bidx_q <= 2'd0;
    end else begin
      typ_q  <= typ_d;
      addr_q <= addr_d;
      data_q <= data_d;
      opb_q  <= opb_d;
      fun_q  <= fun_d;
      pen_q  <= pen_d;
      ptyp_q <= ptyp_d;
      bidx_q <= bidx_d;
    end
  end

  uart_byte_ser #(
    .BIT_CYCLES(BIT_CYCLES),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk    (CLK),
    .rst    (RST),
    .load   (ser_load),
    .byte_in(byte_sel),
    .par_en (ser_pen),
    .par_typ(ser_ptyp),
    .idle   (ser_idle),
    .done   (ser_done),
    .tx     (TX_OUT)
  );

endmodule

// File: tb/tb_host_cmd_tx.sv
// Bench for host_cmd_tx: scoreboard of expected characters
// checked cycle-exact against the serial line.
module tb_host_cmd_tx;

  typedef struct {
    logic [7:0] b;
    bit         pen;
    bit         ptyp;
    bit         last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] vld;
  logic [1:0] ctype;
  logic [3:0] addr;
  logic [7:0] data;
  logic [7:0] opb;
  logic [3:0] fun;
  logic       pen;
  logic       ptyp;
  logic [1:0] rdy, busy, done, tx;

  exp_t sbq[$];
  int   sel;
  int   n_pass;
  int   n_chk;

  always #5 clk = ~clk;

  host_cmd_tx #(.BIT_CYCLES(4)) dut4 (
    .CLK(clk), .RST(rst),
    .CMD_VALID(vld[0]), .CMD_READY(rdy[0]),
    .CMD_TYPE(ctype), .CMD_ADDR(addr),
    .CMD_DATA(data), .CMD_OPB(opb), .CMD_FUN(fun),
    .PAR_EN(pen), .PAR_TYP(ptyp),
    .TX_OUT(tx[0]), .BUSY(busy[0]),
    .FRAME_DONE(done[0])
  );

  host_cmd_tx #(.BIT_CYCLES(1)) dut1 (
    .CLK(clk), .RST(rst),
    .CMD_VALID(vld[1]), .CMD_READY(rdy[1]),
    .CMD_TYPE(ctype), .CMD_ADDR(addr),
    .CMD_DATA(data), .CMD_OPB(opb), .CMD_FUN(fun),
    .PAR_EN(pen), .PAR_TYP(ptyp),
    .TX_OUT(tx[1]), .BUSY(busy[1]),
    .FRAME_DONE(done[1])
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic push(logic [7:0] b, bit pe, bit pt,
                      bit last);
    exp_t e;
    e.b = b; e.pen = pe; e.ptyp = pt; e.last = last;
    sbq.push_back(e);
  endtask

  task automatic send(int s, logic [1:0] t,
                      logic [3:0] a, logic [7:0] d,
                      logic [7:0] b, logic [3:0] f,
                      logic pe, logic pt, bit hold);
    bit ok;
    case (t)
      2'd0: begin
        push(8'hAA, pe, pt, 0);
        push({4'h0, a}, pe, pt, 0);
        push(d, pe, pt, 1);
      end
      2'd1: begin
        push(8'hBB, pe, pt, 0);
        push({4'h0, a}, pe, pt, 1);
      end
      2'd2: begin
        push(8'hCC, pe, pt, 0);
        push(d, pe, pt, 0);
        push(b, pe, pt, 0);
        push({4'h0, f}, pe, pt, 1);
      end
      default: begin
        push(8'hDD, pe, pt, 0);
        push({4'h0, f}, pe, pt, 1);
      end
    endcase
    ctype = t; addr = a; data = d; opb = b;
    fun = f; pen = pe; ptyp = pt;
    vld[s] = 1'b1;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = rdy[s] && !rst;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      vld[s] = 1'b0;
      ctype = 2'($urandom);
      addr  = 4'($urandom);
      data  = 8'($urandom);
      opb   = 8'($urandom);
      fun   = 4'($urandom);
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (sbq.size() == 0) && rdy[sel];
    end
    chk("drain", sbq.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame();
    exp_t        it;
    logic [10:0] eb, gb;
    int          nb, bc, errs, early, busyerr;
    bit          fin;
    bc = (sel == 1) ? 1 : 4;
    early = 0; busyerr = 0; fin = 0;
    while (!fin) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
        return;
      end
      it = sbq.pop_front();
      nb = it.pen ? 11 : 10;
      eb = '1;
      eb[0] = 1'b0;
      eb[8:1] = it.b;
      if (it.pen) eb[9] = (^it.b) ^ it.ptyp;
      gb = '1;
      errs = 0;
      for (int b = 0; b < nb; b++) begin
        for (int c = 0; c < bc; c++) begin
          @(negedge clk);
          if (rst) begin
            sbq.delete();
            chk("rst_no_done", early, 0);
            @(negedge clk);
            chk("rst_tx", tx[sel], 1);
            chk("rst_ready", rdy[sel], 1);
            chk("rst_busy", busy[sel], 0);
            chk("rst_done", done[sel], 0);
            return;
          end
          if (c == 0) gb[b] = tx[sel];
          if (tx[sel] !== eb[b]) errs++;
          if (!busy[sel]) busyerr++;
          if (it.last && b == nb - 1 && c == bc - 1)
            chk("frame_done", done[sel], 1);
          else if (done[sel])
            early++;
        end
      end
      chk("char_bits", gb, eb);
      chk("char_cycle_errs", errs, 0);
      fin = it.last;
    end
    chk("done_spurious", early, 0);
    chk("busy_in_frame", busyerr, 0);
    @(negedge clk);
    chk("ready_after", rdy[sel], 1);
    chk("busy_after", busy[sel], 0);
    chk("idle_high", tx[sel], 1);
  endtask

  initial begin
    @(negedge clk);
    forever begin
      if (vld[sel] && rdy[sel] && !rst) run_frame();
      else @(negedge clk);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: sim time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] t;
    n_pass = 0; n_chk = 0; sel = 0;
    rst = 1'b1; vld = 2'b00; ctype = 2'd0;
    addr = '0; data = '0; opb = '0; fun = '0;
    pen = 1'b0; ptyp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_tx", tx[k], 1);
      chk("reset_busy", busy[k], 0);
      chk("reset_done", done[k], 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("release_ready0", rdy[0], 1);
    chk("release_ready1", rdy[1], 1);
    @(posedge clk);
    #1;

    send(0, 2'd0, 4'h2, 8'h81, 8'h00, 4'h0, 1, 0, 0);
    drain();
    send(0, 2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    drain();
    send(0, 2'd2, 4'h0, 8'h05, 8'h03, 4'h1, 1, 1, 0);
    drain();

    send(0, 2'd3, 4'h0, 8'h00, 8'h00, 4'h5, 0, 0, 1);
    send(0, 2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 1, 0, 0);
    drain();

    send(0, 2'd2, 4'h0, 8'hF0, 8'h3C, 4'h9, 1, 1, 0);
    repeat (13) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 2'd1, 4'h7, 8'h00, 8'h00, 4'h0, 1, 0, 0);
    drain();

    for (int r = 0; r < 6; r++) begin
      t = 2'($urandom_range(0, 3));
      send(0, t, 4'($urandom), 8'($urandom),
           8'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 0);
      drain();
    end

    sel = 1;
    send(1, 2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 0, 0, 0);
    drain();
    send(1, 2'd2, 4'h0, 8'h96, 8'h7E, 4'hC, 1, 1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
